// File: rtl/wdt_feeder_if.sv
// Signal bundle between a supervisor (master) and the watchdog feeder (slave).
interface wdt_feeder_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic [WIDTH-1:0] feed_interval;
  logic             heartbeat;
  logic [WIDTH-1:0] hb_timeout;
  logic             wdt_warning;
  logic             wdt_reset;
  logic             feed;
  logic [1:0]       state;
  logic             hb_lost;
  logic             wdt_fired;
  logic [15:0]      feed_count;

  modport master (
    output enable, feed_interval, heartbeat, hb_timeout, wdt_warning, wdt_reset,
    input  feed, state, hb_lost, wdt_fired, feed_count
  );

  modport slave (
    input  enable, feed_interval, heartbeat, hb_timeout, wdt_warning, wdt_reset,
    output feed, state, hb_lost, wdt_fired, feed_count
  );
endinterface

// File: rtl/wdt_feeder.sv
// Watchdog feeder: periodic and warning-driven feeds, gated by a heartbeat
// liveness check; latches into STARVE on heartbeat loss or watchdog expiry.
module wdt_feeder #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  wdt_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_URGENT = 2'd2,
    ST_STARVE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] int_cnt_q, int_cnt_d;
  logic [WIDTH-1:0] hb_cnt_q, hb_cnt_d;
  logic             feed_q, feed_d;
  logic             hb_lost_q, hb_lost_d;
  logic             wdt_fired_q, wdt_fired_d;
  logic [15:0]      feed_count_q, feed_count_d;

  logic             hb_expired;
  logic             periodic_due;
  logic             urgent_due;

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      int_cnt_q    <= CNT_ZERO;
      hb_cnt_q     <= CNT_ZERO;
      feed_q       <= 1'b0;
      hb_lost_q    <= 1'b0;
      wdt_fired_q  <= 1'b0;
      feed_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      int_cnt_q    <= int_cnt_d;
      hb_cnt_q     <= hb_cnt_d;
      feed_q       <= feed_d;
      hb_lost_q    <= hb_lost_d;
      wdt_fired_q  <= wdt_fired_d;
      feed_count_q <= feed_count_d;
    end
  end

  // Next-state logic; >= comparisons make a lowered threshold fire at once.
  always_comb begin
    state_d      = state_q;
    int_cnt_d    = int_cnt_q;
    hb_cnt_d     = hb_cnt_q;
    feed_d       = 1'b0;
    hb_lost_d    = hb_lost_q;
    wdt_fired_d  = wdt_fired_q;
    feed_count_d = feed_count_q;

    hb_expired   = (!bus.heartbeat) && (hb_cnt_q >= bus.hb_timeout);
    periodic_due = (int_cnt_q >= bus.feed_interval);
    urgent_due   = (state_q == ST_RUN) && bus.wdt_warning;

    if (!bus.enable) begin
      state_d      = ST_IDLE;
      int_cnt_d    = CNT_ZERO;
      hb_cnt_d     = CNT_ZERO;
      hb_lost_d    = 1'b0;
      wdt_fired_d  = 1'b0;
      feed_count_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_RUN;
          int_cnt_d    = CNT_ZERO;
          hb_cnt_d     = CNT_ZERO;
          hb_lost_d    = 1'b0;
          wdt_fired_d  = 1'b0;
          feed_count_d = 16'd0;
        end
        ST_RUN, ST_URGENT: begin
          if (hb_expired || bus.wdt_reset) begin
            // Counters freeze; both flags may be set by the same cycle.
            state_d     = ST_STARVE;
            hb_lost_d   = hb_lost_q | hb_expired;
            wdt_fired_d = wdt_fired_q | bus.wdt_reset;
          end else begin
            feed_d    = periodic_due || urgent_due;
            int_cnt_d = feed_d ? CNT_ZERO : (int_cnt_q + CNT_ONE);
            hb_cnt_d  = bus.heartbeat ? CNT_ZERO : (hb_cnt_q + CNT_ONE);
            state_d   = bus.wdt_warning ? ST_URGENT : ST_RUN;
            if (feed_d && (feed_count_q != 16'hFFFF)) begin
              feed_count_d = feed_count_q + 16'd1;
            end else begin
              feed_count_d = feed_count_q;
            end
          end
        end
        ST_STARVE: begin
          state_d = ST_STARVE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.feed       = feed_q;
  assign bus.state      = state_q;
  assign bus.hb_lost    = hb_lost_q;
  assign bus.wdt_fired  = wdt_fired_q;
  assign bus.feed_count = feed_count_q;

endmodule

// File: tb/tb_wdt_feeder.sv
// Self-checking bench for wdt_feeder: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_wdt_feeder;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  wdt_feeder_if #(.WIDTH(W)) bus_if ();

  wdt_feeder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural model: cycles since last feed / heartbeat, mode and flags.
  int m_state, m_since_feed, m_since_hb, m_count;
  bit m_feed, m_hb_lost, m_fired;

  task automatic model_reset();
    m_state = 0; m_since_feed = 0; m_since_hb = 0; m_count = 0;
    m_feed = 1'b0; m_hb_lost = 1'b0; m_fired = 1'b0;
  endtask

  task automatic model_step();
    bit starve_hb;
    m_feed = 1'b0;
    if (!bus_if.enable) begin
      model_reset();
    end else if (m_state == 0) begin
      m_state = 1; m_since_feed = 0; m_since_hb = 0;
    end else if (m_state == 1 || m_state == 2) begin
      starve_hb = !bus_if.heartbeat && (m_since_hb >= int'(bus_if.hb_timeout));
      if (starve_hb || bus_if.wdt_reset) begin
        m_state = 3;
        if (starve_hb) m_hb_lost = 1'b1;
        if (bus_if.wdt_reset) m_fired = 1'b1;
      end else begin
        m_feed = (m_since_feed >= int'(bus_if.feed_interval)) ||
                 (m_state == 1 && bus_if.wdt_warning);
        m_since_feed = m_feed ? 0 : m_since_feed + 1;
        m_since_hb   = bus_if.heartbeat ? 0 : m_since_hb + 1;
        m_state      = bus_if.wdt_warning ? 2 : 1;
        if (m_feed && m_count < 65535) m_count = m_count + 1;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("feed",       32'(bus_if.feed),       32'(m_feed));
    check_eq("state",      32'(bus_if.state),      32'(m_state));
    check_eq("hb_lost",    32'(bus_if.hb_lost),    32'(m_hb_lost));
    check_eq("wdt_fired",  32'(bus_if.wdt_fired),  32'(m_fired));
    check_eq("feed_count", 32'(bus_if.feed_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick_fast();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_if.heartbeat   = 1'b0;
    bus_if.wdt_warning = 1'b0;
    bus_if.wdt_reset   = 1'b0;
  endtask

  task automatic restart(input int fi, input int hbt);
    clear_inputs();
    bus_if.enable = 1'b0;
    tick();
    bus_if.feed_interval = W'(fi);
    bus_if.hb_timeout    = W'(hbt);
    bus_if.enable        = 1'b1;
    tick();
    check_eq("run_entry", 32'(bus_if.state), 32'd1);
  endtask

  // Reset asserted between edges must clear every output before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst_zero", {bus_if.feed, bus_if.state, bus_if.hb_lost, bus_if.wdt_fired,
                           bus_if.feed_count, 11'd0}, 32'd0);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus_if.enable        = 1'b0;
    bus_if.feed_interval = W'(4);
    bus_if.hb_timeout    = W'(100);
    clear_inputs();
    model_reset();
    #3;
    compare_all();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Periodic feeds with regular heartbeats.
    restart(4, 100);
    for (int k = 1; k <= 20; k++) begin
      bus_if.heartbeat = (k % 10 == 9);
      tick();
      check_eq("p_feed", 32'(bus_if.feed), 32'(k % 5 == 0));
    end
    check_eq("p_count", 32'(bus_if.feed_count), 32'd4);

    // Heartbeat loss.
    restart(4, 8);
    for (int k = 1; k <= 9; k++) tick();
    check_eq("hl_state", 32'(bus_if.state), 32'd3);
    check_eq("hl_flag",  32'(bus_if.hb_lost), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("hl_nofeed", 32'(bus_if.feed), 32'd0);
    end

    // Urgent feed for a six-cycle warning.
    restart(20, 1000);
    repeat (3) tick();
    bus_if.wdt_warning = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check_eq("u_state", 32'(bus_if.state), 32'd2);
      check_eq("u_feed",  32'(bus_if.feed), 32'(j == 1));
    end
    bus_if.wdt_warning = 1'b0;
    tick();
    check_eq("u_back", 32'(bus_if.state), 32'd1);
    check_eq("u_count", 32'(bus_if.feed_count), 32'd1);

    // Heartbeat exactly at the timeout boundary keeps RUN.
    restart(50, 5);
    repeat (5) tick();
    bus_if.heartbeat = 1'b1;
    tick();
    check_eq("hb_edge", 32'(bus_if.state), 32'd1);
    bus_if.heartbeat = 1'b0;

    // Warning coinciding with a periodic feed: one pulse, count +1.
    restart(3, 100);
    repeat (3) tick();
    bus_if.wdt_warning = 1'b1;
    tick();
    check_eq("col_feed",  32'(bus_if.feed), 32'd1);
    check_eq("col_count", 32'(bus_if.feed_count), 32'd1);
    tick();
    check_eq("col_single", 32'(bus_if.feed), 32'd0);
    bus_if.wdt_warning = 1'b0;

    // Lowering the interval mid-run fires on the next cycle.
    restart(30, 200);
    repeat (10) tick();
    bus_if.feed_interval = W'(2);
    tick();
    check_eq("lower_fi", 32'(bus_if.feed), 32'd1);

    // Watchdog expiry and recovery through enable.
    restart(6, 200);
    repeat (2) tick();
    bus_if.wdt_reset = 1'b1;
    tick();
    bus_if.wdt_reset = 1'b0;
    check_eq("wf_state", 32'(bus_if.state), 32'd3);
    check_eq("wf_flag",  32'(bus_if.wdt_fired), 32'd1);
    bus_if.enable = 1'b0;
    tick();
    check_eq("wf_idle",  {30'd0, bus_if.state}, 32'd0);
    check_eq("wf_clear", 32'(bus_if.wdt_fired), 32'd0);
    bus_if.enable = 1'b1;
    tick();
    check_eq("wf_run", 32'(bus_if.state), 32'd1);

    // Async reset right after a feed pulse.
    restart(2, 200);
    repeat (3) tick();
    check_eq("ar_feed", 32'(bus_if.feed), 32'd1);
    async_reset();
    tick();
    check_eq("ar_rerun", 32'(bus_if.state), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (bus_if.enable) bus_if.enable = ($urandom_range(0, 99) >= 2);
      else               bus_if.enable = ($urandom_range(0, 1) == 1);
      bus_if.heartbeat = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) == 0) bus_if.wdt_warning = ~bus_if.wdt_warning;
      bus_if.wdt_reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 32) == 0) bus_if.feed_interval = W'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) bus_if.hb_timeout    = W'($urandom_range(2, 40));
      if ($urandom_range(0, 199) == 0) async_reset();
      else tick();
    end

    // Counter saturation with a feed every cycle.
    restart(0, 4000);
    bus_if.heartbeat = 1'b1;
    for (int i = 0; i < 65540; i++) tick_fast();
    compare_all();
    check_eq("sat_count", 32'(bus_if.feed_count), 32'h0000FFFF);
    check_eq("sat_feed",  32'(bus_if.feed), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
